// File: rtl/text_char_buffer.sv
// Character RAM for the OLED text engine: cursor-driven byte writer with
// CR/LF/BS/FF handling, blanking sweep, and a 1-cycle registered read port.
//
// Ports:
//   clk_i, reset_i (sync, active-low)
//   charValid_i/charData_i/charReady_o : byte stream handshake
//   clear_i        : blank buffer and home cursor
//   charAddress_i  : read cell index; charOutput_o : registered read data
//   cursor_o       : current write cell; busy_o : clear sweep running
module text_char_buffer #(
  parameter int          COLS   = 16,
  parameter int          ROWS   = 4,
  parameter int          ADDR_W = 6,
  parameter logic [7:0]  BLANK  = 8'h20
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              charValid_i,
  input  logic [7:0]        charData_i,
  output logic              charReady_o,
  input  logic              clear_i,
  input  logic [ADDR_W-1:0] charAddress_i,
  output logic [7:0]        charOutput_o,
  output logic [ADDR_W-1:0] cursor_o,
  output logic              busy_o
);

  localparam int CELLS = COLS * ROWS;
  localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(CELLS - 1);
  localparam logic [ADDR_W-1:0] COLS_A = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] LROW_A = ADDR_W'((ROWS - 1) * COLS);

  typedef enum logic {
    S_CLEAR,
    S_IDLE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] sweep_q, sweep_d;
  logic [ADDR_W-1:0] cursor_q, cursor_d;
  logic [7:0]        out_q;
  logic [7:0]        mem [CELLS];

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [7:0]        wdata;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] lf_next;
  logic [ADDR_W-1:0] bs_prev;
  logic              printable;

  always_comb begin
    row_base  = cursor_q - (cursor_q % COLS_A);
    lf_next   = (row_base == LROW_A) ? '0 : row_base + COLS_A;
    bs_prev   = (cursor_q == '0) ? '0 : cursor_q - 1'b1;
    printable = (charData_i >= 8'h20) && (charData_i <= 8'h7E);
  end

  always_comb begin
    state_d  = state_q;
    sweep_d  = sweep_q;
    cursor_d = cursor_q;
    we       = 1'b0;
    waddr    = cursor_q;
    wdata    = charData_i;
    unique case (state_q)
      S_CLEAR: begin
        we      = 1'b1;
        waddr   = sweep_q;
        wdata   = BLANK;
        sweep_d = sweep_q + 1'b1;
        if (sweep_q == LAST) state_d = S_IDLE;
      end
      S_IDLE: begin
        // clear_i beats a same-cycle byte; the byte is simply dropped
        if (clear_i) begin
          cursor_d = '0;
          sweep_d  = '0;
          state_d  = S_CLEAR;
        end else if (charValid_i) begin
          unique case (1'b1)
            printable: begin
              we       = 1'b1;
              cursor_d = cursor_q + 1'b1;
            end
            (charData_i == 8'h0D): cursor_d = row_base;
            (charData_i == 8'h0A): cursor_d = lf_next;
            (charData_i == 8'h08): begin
              we       = 1'b1;
              waddr    = bs_prev;
              wdata    = BLANK;
              cursor_d = bs_prev;
            end
            (charData_i == 8'h0C): begin
              cursor_d = '0;
              sweep_d  = '0;
              state_d  = S_CLEAR;
            end
            default: ;
          endcase
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q  <= S_CLEAR;
      sweep_q  <= '0;
      cursor_q <= '0;
      out_q    <= 8'h00;
    end else begin
      state_q  <= state_d;
      sweep_q  <= sweep_d;
      cursor_q <= cursor_d;
      out_q    <= mem[charAddress_i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i && we) mem[waddr] <= wdata;
  end

  assign charReady_o  = (state_q == S_IDLE);
  assign busy_o       = (state_q == S_CLEAR);
  assign charOutput_o = out_q;
  assign cursor_o     = cursor_q;

endmodule

// File: tb/tb_text_char_buffer.sv
// Directed bench for text_char_buffer: reset sweep, writes, cursor
// control codes, wrap, clear priority and mid-sweep reset.
module tb_text_char_buffer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       charValid = 1'b0;
  logic [7:0] charData = 8'h00;
  logic       charReady;
  logic       clear = 1'b0;
  logic [5:0] charAddress = 6'd0;
  logic [7:0] charOutput;
  logic [5:0] cursor;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  text_char_buffer dut (
    .clk_i(clk),
    .reset_i(reset_n),
    .charValid_i(charValid),
    .charData_i(charData),
    .charReady_o(charReady),
    .clear_i(clear),
    .charAddress_i(charAddress),
    .charOutput_o(charOutput),
    .cursor_o(cursor),
    .busy_o(busy)
  );

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    charValid = 1'b1;
    charData  = b;
    @(negedge clk);
    charValid = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, output logic [7:0] d);
    @(negedge clk);
    charAddress = a;
    @(negedge clk);
    d = charOutput;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (!charReady && k < 200) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (charReady !== 1'b1) begin
      n_err++;
      $display("FAIL wait_idle: ready=%b required 1", charReady);
    end
  endtask

  task automatic test_reset();
    int k;
    int bad;
    logic [7:0] d;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, charReady} !== 2'b10) begin
      n_err++;
      $display("FAIL rst_flags: busy,ready=%b required 10", {busy, charReady});
    end
    n_cmp++;
    if (cursor !== 6'd0) begin
      n_err++;
      $display("FAIL rst_cursor: %0d required 0", cursor);
    end
    n_cmp++;
    if (charOutput !== 8'h00) begin
      n_err++;
      $display("FAIL rst_out: %h required 00", charOutput);
    end
    reset_n = 1'b1;
    k = 0;
    while (!charReady && k < 200) begin
      @(negedge clk);
      k++;
      if (k == 63) begin
        n_cmp++;
        if (busy !== 1'b1 || charReady !== 1'b0) begin
          n_err++;
          $display("FAIL rst_sweep63: busy=%b ready=%b required 1 0", busy, charReady);
        end
      end
    end
    n_cmp++;
    if (k != 64) begin
      n_err++;
      $display("FAIL rst_sweep_len: %0d cycles required 64", k);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL rst_busy_fall: %b required 0", busy);
    end
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      rd(6'(i), d);
      if (d !== 8'h20) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL rst_blank: %0d cells non-blank required 0", bad);
    end
    n_cmp++;
    if (cursor !== 6'd0) begin
      n_err++;
      $display("FAIL rst_cursor2: %0d required 0", cursor);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    @(negedge clk);
    charValid = 1'b1;
    charData  = 8'h48;
    @(negedge clk);
    charData  = 8'h49;
    @(negedge clk);
    charValid = 1'b0;
    n_cmp++;
    if (cursor !== 6'd2) begin
      n_err++;
      $display("FAIL hi_cursor: %0d required 2", cursor);
    end
    rd(6'd0, d);
    n_cmp++;
    if (d !== 8'h48) begin
      n_err++;
      $display("FAIL hi_cell0: %h required 48", d);
    end
    charAddress = 6'd1;
    #1;
    n_cmp++;
    if (charOutput !== 8'h48) begin
      n_err++;
      $display("FAIL hi_latency: %h required 48 (old)", charOutput);
    end
    @(negedge clk);
    n_cmp++;
    if (charOutput !== 8'h49) begin
      n_err++;
      $display("FAIL hi_cell1: %h required 49", charOutput);
    end
  endtask

  task automatic test_cr_lf();
    repeat (18) send(8'h2E);
    n_cmp++;
    if (cursor !== 6'd20) begin
      n_err++;
      $display("FAIL crlf_setup: %0d required 20", cursor);
    end
    send(8'h0D);
    n_cmp++;
    if (cursor !== 6'd16) begin
      n_err++;
      $display("FAIL cr: %0d required 16", cursor);
    end
    send(8'h0A);
    n_cmp++;
    if (cursor !== 6'd32) begin
      n_err++;
      $display("FAIL lf: %0d required 32", cursor);
    end
    repeat (18) send(8'h2E);
    send(8'h01);
    n_cmp++;
    if (cursor !== 6'd50) begin
      n_err++;
      $display("FAIL other_byte: %0d required 50", cursor);
    end
    send(8'h0A);
    n_cmp++;
    if (cursor !== 6'd0) begin
      n_err++;
      $display("FAIL lf_wrap: %0d required 0", cursor);
    end
  endtask

  task automatic test_wrap_bs();
    logic [7:0] d;
    for (int i = 0; i < 64; i++) send(8'h61 + 8'(i % 26));
    n_cmp++;
    if (cursor !== 6'd0) begin
      n_err++;
      $display("FAIL fill_wrap: %0d required 0", cursor);
    end
    rd(6'd63, d);
    n_cmp++;
    if (d !== 8'h6C) begin
      n_err++;
      $display("FAIL fill_cell63: %h required 6c", d);
    end
    send(8'h08);
    n_cmp++;
    if (cursor !== 6'd0) begin
      n_err++;
      $display("FAIL bs_at0_cursor: %0d required 0", cursor);
    end
    rd(6'd0, d);
    n_cmp++;
    if (d !== 8'h20) begin
      n_err++;
      $display("FAIL bs_at0_cell: %h required 20", d);
    end
    send(8'h5A);
    n_cmp++;
    if (cursor !== 6'd1) begin
      n_err++;
      $display("FAIL z_cursor: %0d required 1", cursor);
    end
    rd(6'd0, d);
    n_cmp++;
    if (d !== 8'h5A) begin
      n_err++;
      $display("FAIL z_cell0: %h required 5a", d);
    end
    send(8'h41);
    send(8'h08);
    n_cmp++;
    if (cursor !== 6'd1) begin
      n_err++;
      $display("FAIL bs_mid_cursor: %0d required 1", cursor);
    end
    rd(6'd1, d);
    n_cmp++;
    if (d !== 8'h20) begin
      n_err++;
      $display("FAIL bs_mid_cell: %h required 20", d);
    end
  endtask

  task automatic test_clear();
    int k;
    int bad;
    logic [7:0] d;
    send(8'h0C);
    n_cmp++;
    if (busy !== 1'b1 || cursor !== 6'd0) begin
      n_err++;
      $display("FAIL ff: busy=%b cursor=%0d required 1 0", busy, cursor);
    end
    wait_idle();
    repeat (10) send(8'h6B);
    charAddress = 6'd10;
    @(negedge clk);
    clear     = 1'b1;
    charValid = 1'b1;
    charData  = 8'h41;
    @(negedge clk);
    clear     = 1'b0;
    charValid = 1'b0;
    k = 0;
    while (busy && k < 200) begin
      k++;
      if (k == 2) begin
        n_cmp++;
        if (charOutput !== 8'h20) begin
          n_err++;
          $display("FAIL clr_no_write: cell10=%h required 20", charOutput);
        end
      end
      @(negedge clk);
    end
    n_cmp++;
    if (k != 64) begin
      n_err++;
      $display("FAIL clr_len: busy %0d cycles required 64", k);
    end
    n_cmp++;
    if (charReady !== 1'b1 || cursor !== 6'd0) begin
      n_err++;
      $display("FAIL clr_end: ready=%b cursor=%0d required 1 0", charReady, cursor);
    end
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      rd(6'(i), d);
      if (d !== 8'h20) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL clr_blank: %0d cells non-blank required 0", bad);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    repeat (30) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    n_cmp++;
    if (busy !== 1'b1 || charReady !== 1'b0) begin
      n_err++;
      $display("FAIL mid_rst_flags: busy=%b ready=%b required 1 0", busy, charReady);
    end
    k = 0;
    while (!charReady && k < 200) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (k != 64) begin
      n_err++;
      $display("FAIL mid_rst_len: %0d cycles required 64", k);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_cr_lf();
    test_wrap_bs();
    test_clear();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
